// File: rtl/freq_counter_pkg.sv
// Shared definitions for the frequency-counter sequencer: register map, CTRL bits,
// FSM state encoding and the ten-phase sample decoder.
package freq_counter_pkg;

  localparam logic [31:0] ADR_CTRL  = 32'h08;
  localparam logic [31:0] ADR_COUNT = 32'h09;
  localparam logic [31:0] ADR_PHASE = 32'h0A;

  localparam int CTRL_START_BIT = 7;
  localparam int CTRL_DONE_BIT  = 6;
  localparam int CTRL_RESET_BIT = 0;

  localparam logic [31:0] CTRL_RESET = 32'(1) << CTRL_RESET_BIT;
  localparam logic [31:0] CTRL_START = 32'(1) << CTRL_START_BIT;
  localparam logic [31:0] CTRL_CLEAR = 32'h0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_ARM,
    S_WAIT,
    S_POLL,
    S_RD_CNT,
    S_RD_PH,
    S_DISARM,
    S_CALC,
    S_OUT
  } state_t;

  typedef struct packed {
    logic       err;
    logic [3:0] idx;
  } phase_dec_t;

  // Thermometer-style snapshots of the five-tap ring, MSB = ref clock 1; entry i is index i.
  localparam logic [0:9][4:0] PHASE_TABLE = {
    5'b10011, 5'b10001, 5'b11001, 5'b11000, 5'b11100,
    5'b01100, 5'b01110, 5'b00110, 5'b00111, 5'b00011
  };

  function automatic phase_dec_t phase_decode(input logic [4:0] pat);
    phase_dec_t r;
    r.err = 1'b1;
    r.idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (pat == PHASE_TABLE[i]) begin
        r.err = 1'b0;
        r.idx = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_single_master.sv
// Single classic Wishbone cycle engine: one read or write per request, with an
// acknowledge timeout; reports done/err/timeout as one-cycle pulses.
module wb_single_master #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  output logic        rsp_done,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] rsp_rdata,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic        err_i
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  logic [TMR_W-1:0] timer;

  assign sel_o = 4'hF;

  // NOTE: cyc_o/stb_o are flops on the async reset, so a reset drops them at once
  // without waiting for a clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
      timer       <= '0;
      rsp_done    <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_done    <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      if (!cyc_o) begin
        if (req_i) begin
          cyc_o <= 1'b1;
          stb_o <= 1'b1;
          we_o  <= req_we;
          adr_o <= req_adr;
          dat_o <= req_wdata;
          timer <= '0;
        end
      end else if (ack_i) begin
        cyc_o     <= 1'b0;
        stb_o     <= 1'b0;
        we_o      <= 1'b0;
        rsp_done  <= 1'b1;
        rsp_rdata <= dat_i;
      end else if (err_i) begin
        cyc_o   <= 1'b0;
        stb_o   <= 1'b0;
        we_o    <= 1'b0;
        rsp_err <= 1'b1;
      end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
        cyc_o       <= 1'b0;
        stb_o       <= 1'b0;
        we_o        <= 1'b0;
        rsp_timeout <= 1'b1;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_counter_sequencer.sv
// Drives a Wishbone frequency counter through clear/arm/poll/read/disarm and
// turns its coarse count plus phase samples into a 1 ns resolution interval.
module freq_counter_sequencer
  import freq_counter_pkg::*;
#(
  parameter int          ACK_TIMEOUT  = 16,
  parameter logic [31:0] MEAS_TIMEOUT = 32'd200_000_000,
  parameter int          POLL_GAP     = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        start_i,
  input  logic        continuous_i,
  output logic        busy_o,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [36:0] res_interval_o,
  output logic [31:0] res_count_o,
  output logic [2:0]  res_status_o
);

  localparam int GAP_W = $clog2(POLL_GAP) + 1;

  state_t           state;
  logic             req_sent;
  logic             bus_req;
  logic             abort;
  logic [GAP_W-1:0] gap_cnt;
  logic [31:0]      meas_cnt;
  logic [31:0]      count_q;
  logic [9:0]       phase_q;
  logic             calc_step;
  logic [36:0]      prod;
  logic [3:0]       start_idx;
  logic [3:0]       end_idx;

  logic             bus_state;
  logic             cmd_we;
  logic [31:0]      cmd_adr;
  logic [31:0]      cmd_wdata;
  logic             rsp_done;
  logic             rsp_err;
  logic             rsp_timeout;
  logic [31:0]      rsp_rdata;
  logic             rsp_fail;
  logic             rsp_any;
  phase_dec_t       dec_start;
  phase_dec_t       dec_end;
  logic [37:0]      diff;
  logic [36:0]      interval_sat;

  wb_single_master #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_bus (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (bus_req),
    .req_we     (cmd_we),
    .req_adr    (cmd_adr),
    .req_wdata  (cmd_wdata),
    .rsp_done   (rsp_done),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .rsp_rdata  (rsp_rdata),
    .adr_o      (adr_o),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .we_o       (we_o),
    .sel_o      (sel_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .ack_i      (ack_i),
    .err_i      (err_i)
  );

  assign rsp_fail = rsp_err | rsp_timeout;
  assign rsp_any  = rsp_done | rsp_fail;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bus_state = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = ADR_CTRL;
    cmd_wdata = CTRL_CLEAR;
    case (state)
      S_CLR:    begin bus_state = 1'b1; cmd_we = 1'b1; cmd_wdata = CTRL_RESET; end
      S_ARM:    begin bus_state = 1'b1; cmd_we = 1'b1; cmd_wdata = CTRL_START; end
      S_POLL:   bus_state = 1'b1;
      S_RD_CNT: begin bus_state = 1'b1; cmd_adr = ADR_COUNT; end
      S_RD_PH:  begin bus_state = 1'b1; cmd_adr = ADR_PHASE; end
      // A timed-out measurement leaves the counter in reset instead of merely stopped.
      S_DISARM: begin
        bus_state = 1'b1;
        cmd_we    = 1'b1;
        cmd_wdata = abort ? CTRL_RESET : CTRL_CLEAR;
      end
      default: ;
    endcase
  end

  always_comb begin
    dec_start    = phase_decode(phase_q[9:5]);
    dec_end      = phase_decode(phase_q[4:0]);
    diff         = {1'b0, prod} + {34'd0, end_idx} - {34'd0, start_idx};
    interval_sat = diff[37] ? '0 : diff[36:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      req_sent       <= 1'b0;
      bus_req        <= 1'b0;
      abort          <= 1'b0;
      gap_cnt        <= '0;
      meas_cnt       <= '0;
      count_q        <= '0;
      phase_q        <= '0;
      calc_step      <= 1'b0;
      prod           <= '0;
      start_idx      <= '0;
      end_idx        <= '0;
      busy_o         <= 1'b0;
      res_valid_o    <= 1'b0;
      res_interval_o <= '0;
      res_count_o    <= '0;
      res_status_o   <= '0;
    end else begin
      bus_req <= 1'b0;
      if (bus_state && !req_sent) begin
        bus_req  <= 1'b1;
        req_sent <= 1'b1;
      end
      // Every bus response moves the FSM on, so the next bus state re-issues.
      if (rsp_any) req_sent <= 1'b0;
      if (state == S_WAIT || state == S_POLL) meas_cnt <= meas_cnt + 32'd1;

      case (state)
        S_IDLE: if (start_i) begin
          state        <= S_CLR;
          busy_o       <= 1'b1;
          abort        <= 1'b0;
          res_status_o <= '0;
        end
        S_CLR: if (rsp_done) state <= S_ARM;
        S_ARM: if (rsp_done) begin
          state    <= S_WAIT;
          gap_cnt  <= '0;
          meas_cnt <= '0;
        end
        S_WAIT: begin
          if (meas_cnt >= MEAS_TIMEOUT - 32'd1) begin
            state           <= S_DISARM;
            abort           <= 1'b1;
            res_status_o[1] <= 1'b1;
          end else if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
            state   <= S_POLL;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_POLL: if (rsp_done) state <= rsp_rdata[CTRL_DONE_BIT] ? S_RD_CNT : S_WAIT;
        S_RD_CNT: if (rsp_done) begin
          count_q <= rsp_rdata;
          state   <= S_RD_PH;
        end
        S_RD_PH: if (rsp_done) begin
          phase_q <= rsp_rdata[9:0];
          state   <= S_DISARM;
        end
        S_DISARM: begin
          if (abort && rsp_any) begin
            state          <= S_OUT;
            busy_o         <= 1'b0;
            res_valid_o    <= 1'b1;
            res_count_o    <= '0;
            res_interval_o <= '0;
          end else if (rsp_done) begin
            state     <= S_CALC;
            calc_step <= 1'b0;
          end
        end
        S_CALC: begin
          if (!calc_step) begin
            calc_step       <= 1'b1;
            start_idx       <= dec_start.idx;
            end_idx         <= dec_end.idx;
            res_status_o[0] <= dec_start.err | dec_end.err;
            prod            <= ({5'd0, count_q} << 3) + ({5'd0, count_q} << 1);
          end else begin
            state          <= S_OUT;
            busy_o         <= 1'b0;
            res_valid_o    <= 1'b1;
            res_interval_o <= interval_sat;
            res_count_o    <= count_q;
          end
        end
        S_OUT: if (res_ready_i) begin
          res_valid_o <= 1'b0;
          if (continuous_i) begin
            state        <= S_CLR;
            busy_o       <= 1'b1;
            abort        <= 1'b0;
            res_status_o <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Bus faults outside the timeout cleanup write abandon the measurement.
      if (bus_state && rsp_fail && !abort) begin
        state           <= S_OUT;
        busy_o          <= 1'b0;
        res_valid_o     <= 1'b1;
        res_status_o[2] <= 1'b1;
        res_count_o     <= '0;
        res_interval_o  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_freq_counter_sequencer.sv
// Directed bench: Wishbone counter-slave model plus a result scoreboard for the sequencer.
module tb_freq_counter_sequencer;

  typedef struct packed {
    logic [36:0] interval;
    logic [31:0] count;
    logic [2:0]  status;
  } res_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        cyc_o;
  logic        stb_o;
  logic        ack_i;
  logic        err_i = 1'b0;
  logic        start_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic        busy_o;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic [36:0] res_interval_o;
  logic [31:0] res_count_o;
  logic [2:0]  res_status_o;

  int checks = 0;
  int errors = 0;
  res_t       exp_q[$];
  logic [7:0] wr_log[$];

  int          done_poll = 3;
  logic [31:0] count_val = '0;
  logic [9:0]  phase_val = '0;
  logic        block_arm = 1'b0;
  int          poll_cnt;
  int          cyc_len = 0;
  int          last_cyc_len = 0;

  freq_counter_sequencer #(
    .ACK_TIMEOUT (16),
    .MEAS_TIMEOUT(32'd600),
    .POLL_GAP    (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .adr_o         (adr_o),
    .dat_o         (dat_o),
    .dat_i         (dat_i),
    .we_o          (we_o),
    .sel_o         (sel_o),
    .cyc_o         (cyc_o),
    .stb_o         (stb_o),
    .ack_i         (ack_i),
    .err_i         (err_i),
    .start_i       (start_i),
    .continuous_i  (continuous_i),
    .busy_o        (busy_o),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_interval_o(res_interval_o),
    .res_count_o   (res_count_o),
    .res_status_o  (res_status_o)
  );

  always #5 clk_i = ~clk_i;

  // Counter slave: acks one cycle after strobe, reports done on the done_poll-th poll.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_i    <= 1'b0;
      dat_i    <= '0;
      poll_cnt <= 0;
    end else begin
      ack_i <= 1'b0;
      if (cyc_o && stb_o && !ack_i &&
          !(block_arm && we_o && adr_o == 32'h08 && dat_o == 32'h80)) begin
        ack_i <= 1'b1;
        if (we_o) begin
          if (adr_o == 32'h08) begin
            wr_log.push_back(dat_o[7:0]);
            if (dat_o[0]) poll_cnt <= 0;
          end
        end else begin
          case (adr_o)
            32'h08: begin
              poll_cnt <= poll_cnt + 1;
              dat_i    <= (poll_cnt + 1 >= done_poll) ? 32'h40 : 32'h0;
            end
            32'h09:  dat_i <= count_val;
            32'h0A:  dat_i <= {22'd0, phase_val};
            default: dat_i <= 32'hDEAD_BEEF;
          endcase
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (cyc_o) cyc_len = cyc_len + 1;
    else if (cyc_len != 0) begin
      last_cyc_len = cyc_len;
      cyc_len      = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!res_valid_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, ".valid"}, res_valid_o, 1);
  endtask

  task automatic compare_result(input string tag, input res_t r);
    check({tag, ".interval"}, res_interval_o, r.interval);
    check({tag, ".count"}, res_count_o, r.count);
    check({tag, ".status"}, res_status_o, r.status);
  endtask

  task automatic expect_result(input string tag);
    res_t r;
    wait_valid(tag);
    r = exp_q.pop_front();
    compare_result(tag, r);
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic check_log(input string tag, input int n, input logic [31:0] seq);
    logic [31:0] got = '0;
    foreach (wr_log[i]) got = (got << 8) | 32'(wr_log[i]);
    check({tag, ".wr_n"}, wr_log.size(), n);
    check({tag, ".wr_seq"}, got, seq);
  endtask

  initial begin
    res_t r;
    logic stable;
    logic [7:0] first_wr;
    int n;

    // Reset state while rst_i is held
    repeat (2) @(negedge clk_i);
    check("rst.cyc", cyc_o, 0);
    check("rst.stb", stb_o, 0);
    check("rst.we", we_o, 0);
    check("rst.adr", adr_o, 0);
    check("rst.dat", dat_o, 0);
    check("rst.sel", sel_o, 4'hF);
    check("rst.busy", busy_o, 0);
    check("rst.out", {res_valid_o, res_interval_o, res_count_o, res_status_o}, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // A: done on 3rd poll, COUNT=1000, start idx 0, end idx 4
    done_poll = 3; count_val = 32'd1000; phase_val = 10'b10011_11100;
    wr_log.delete();
    exp_q.push_back('{interval: 37'd10004, count: 32'd1000, status: 3'b000});
    pulse_start();
    check("A.busy", busy_o, 1);
    expect_result("A");
    check("A.busy_after", busy_o, 0);
    check_log("A", 3, 32'h0001_8000);

    // B: negative interval saturates to zero
    done_poll = 1; count_val = 32'd0; phase_val = 10'b00011_10011;
    exp_q.push_back('{interval: 37'd0, count: 32'd0, status: 3'b000});
    pulse_start();
    expect_result("B");

    // C: illegal end pattern -> phase_err, end idx 0; 7*10 - 3
    count_val = 32'd7; phase_val = 10'b11000_10101;
    exp_q.push_back('{interval: 37'd67, count: 32'd7, status: 3'b001});
    pulse_start();
    expect_result("C");

    // D: ARM write never acked -> bus_err after a 16-cycle bus cycle
    block_arm = 1'b1; count_val = 32'd9; phase_val = 10'b10011_10011;
    wr_log.delete();
    exp_q.push_back('{interval: 37'd0, count: 32'd0, status: 3'b100});
    pulse_start();
    expect_result("D");
    check("D.cyc_len", last_cyc_len, 16);
    check_log("D", 1, 32'h01);
    block_arm = 1'b0;

    // E: done never reported -> meas_timeout, cleanup write of 0x01
    done_poll = 100000;
    wr_log.delete();
    exp_q.push_back('{interval: 37'd0, count: 32'd0, status: 3'b010});
    pulse_start();
    expect_result("E");
    check_log("E", 3, 32'h0001_8001);

    // F: continuous mode with a stalled consumer, 5*10 + 7 - 1
    done_poll = 1; count_val = 32'd5; phase_val = 10'b10001_00110;
    continuous_i = 1'b1;
    exp_q.push_back('{interval: 37'd56, count: 32'd5, status: 3'b000});
    exp_q.push_back('{interval: 37'd56, count: 32'd5, status: 3'b000});
    pulse_start();
    wait_valid("F1");
    r = exp_q.pop_front();
    compare_result("F1", r);
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk_i);
      if ({res_valid_o, res_interval_o, res_count_o, res_status_o} !== {1'b1, r}) stable = 1'b0;
    end
    check("F1.hold", stable, 1);
    wr_log.delete();
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i  = 1'b0;
    continuous_i = 1'b0;
    check("F1.valid_drop", res_valid_o, 0);
    n = 0;
    while (wr_log.size() == 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    first_wr = 'x;
    if (wr_log.size() != 0) first_wr = wr_log[0];
    check("F.rearm_wr", first_wr, 8'h01);
    expect_result("F2");

    // G: reset in the middle of a poll read
    done_poll = 100000;
    pulse_start();
    n = 0;
    while (!(cyc_o && !we_o && adr_o == 32'h08) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("G.in_poll", {cyc_o, we_o, adr_o}, {1'b1, 1'b0, 32'h08});
    rst_i = 1'b1;
    #1;
    check("G.cyc_async", cyc_o, 0);
    check("G.stb_async", stb_o, 0);
    check("G.busy_async", busy_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    check("G.idle", {busy_o, res_valid_o, cyc_o}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_counter_sequencer.md
FREQ_COUNTER_SEQUENCER -- requirements
Module: freq_counter_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 16, the maximum clk_i cycles to wait for ack_i per bus cycle.
REQ-002 SHALL have parameter MEAS_TIMEOUT, default 32'd200_000_000, the maximum clk_i cycles from arm to done flag.
REQ-003 SHALL have parameter POLL_GAP, default 64, the idle clk_i cycles between successive status polls.
REQ-004 SHALL use one clock clk_i; reset rst_i is asynchronous and active-high.
REQ-005 Ports (name  dir  width  meaning):
 clk_i  in  1  system/bus clock
 rst_i  in  1  async active-high reset
 adr_o  out  32  Wishbone address
 dat_o  out  32  Wishbone write data
 dat_i  in  32  Wishbone read data
 we_o  out  1  write enable
 sel_o  out  4  byte select, always 4'hF
 cyc_o  out  1  bus cycle
 stb_o  out  1  strobe
 ack_i  in  1  slave acknowledge
 err_i  in  1  slave error
 start_i  in  1  one-cycle measurement request
 continuous_i  in  1  when 1, re-arm automatically after each result is accepted
 busy_o  out  1  sequence in progress
 res_valid_o  out  1  result available
 res_ready_i  in  1  consumer accepts result
 res_interval_o  out  37  interval for 1000 input periods, in 1 ns units
 res_count_o  out  32  raw coarse count
 res_status_o  out  3  {bus_err, meas_timeout, phase_err}

Function
REQ-006 Counter register map SHALL be: CTRL 0x08 (bit7 start, bit6 done, bit0 reset), COUNT 0x09, PHASE 0x0A (bits 9:5 start sample, 4:0 end sample; MSB = ref clock 1).
REQ-007 Bus cycles SHALL be single classic cycles: cyc_o/stb_o asserted together with adr_o/dat_o/we_o stable, held until ack_i or err_i, then deasserted for at least one cycle.
REQ-008 FSM states SHALL be IDLE, CLR, ARM, WAIT, POLL, RD_CNT, RD_PH, DISARM, CALC, OUT.
REQ-009 IDLE->CLR on start_i; start_i outside IDLE SHALL be ignored.
REQ-010 CLR: write CTRL=0x01; ARM: write CTRL=0x80; ARM->WAIT.
REQ-011 WAIT: count POLL_GAP cycles, then POLL (read CTRL); if dat_i[6]=1 ->RD_CNT, else ->WAIT.
REQ-012 RD_CNT latches COUNT, RD_PH latches PHASE[9:0], DISARM writes CTRL=0x00, then CALC.
REQ-013 Phase decode SHALL map 10011,10001,11001,11000,11100,01100,01110,00110,00111,00011 to index 0..9; any other pattern gives index 0 and sets phase_err.
REQ-014 CALC SHALL compute interval = count*10 + end_idx - start_idx, using (count<<3)+(count<<1) at 37 bits; a negative result saturates to 0; a multi-cycle CALC is permitted, max 4 cycles.
REQ-015 OUT: res_valid_o=1 with outputs stable until res_valid_o&&res_ready_i; then ->CLR if continuous_i=1, else ->IDLE.
REQ-016 An ack wait exceeding ACK_TIMEOUT, or err_i, SHALL set bus_err, drop cyc_o/stb_o, and go to OUT with count and interval = 0.
REQ-017 MEAS_TIMEOUT elapsing in WAIT/POLL SHALL set meas_timeout, issue a CTRL=0x01 write (errors ignored), then go to OUT with zeros.
REQ-018 busy_o SHALL be 1 in every state except IDLE and OUT.
REQ-019 res_status_o SHALL clear on entry to CLR.

Reset
REQ-020 rst_i SHALL force IDLE, cyc_o=stb_o=we_o=0, adr_o=dat_o=0, sel_o=4'hF, res_valid_o=0, busy_o=0, res_interval_o=0, res_count_o=0, res_status_o=0, and clear all timers.
REQ-021 Reset mid bus cycle SHALL drop cyc_o/stb_o immediately and asynchronously.

Structure
REQ-022 Package freq_counter_pkg SHALL hold the register addresses, CTRL bit positions, FSM state enum, and the phase decode table/function.
REQ-023 Sub-module wb_single_master SHALL perform one read/write with its ACK_TIMEOUT handling and report done/err/timeout to the FSM.

Verification
REQ-024 start_i with a slave model reporting done on the 3rd poll, COUNT=1000, PHASE=10'b10011_11100 -> interval=10004, status=0, write sequence 0x01,0x80,0x00.
REQ-025 COUNT=0, PHASE start 00011 (idx 9), end 10011 (idx 0) -> interval saturates to 0.
REQ-026 PHASE end field 10101 -> phase_err=1, end_idx=0, interval=count*10-start_idx.
REQ-027 Slave never acks the ARM write -> cyc_o drops after 16 cycles, bus_err=1, res_valid_o=1.
REQ-028 continuous_i=1 with res_ready_i held low 50 cycles -> outputs hold stable; after acceptance the next CTRL=0x01 write follows.
REQ-029 rst_i asserted mid POLL read -> cyc_o=0 within the same cycle, FSM=IDLE, no res_valid_o.
